// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared constants for the push-button conditioning block.
//                Provides the pressed-level encodings, the default
//                synchroniser/debounce depths and a helper that maps the
//                ACTIVE_LOW parameter to the idle (released) input level.
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    localparam logic BTN_PRESSED_LOW  = 1'b0;
    localparam logic BTN_PRESSED_HIGH = 1'b1;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1;

    // Level the pin rests at when nobody is touching the button.
    function automatic logic released_level(input int active_low);
        return (active_low != 0) ? ~BTN_PRESSED_LOW : ~BTN_PRESSED_HIGH;
    endfunction

endpackage : btn_pkg
`default_nettype wire

// File: rtl/sync_button_if.sv
`default_nettype none
// ============================================================================
//  Module      : btn_if
//  Description : Button pin / press-event bundle.
//                  in  - raw asynchronous button level from the board pin
//                  out - one-cycle pulse per accepted press
//                master : the board/stimulus side (drives in, observes out)
//                slave  : the conditioning block (samples in, drives out)
//  Revision    : 1.0 - initial release
// ============================================================================
interface btn_if;

    logic in;
    logic out;

    modport master (output in, input  out);
    modport slave  (input  in, output out);

endinterface : btn_if
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
//  Module      : sync_chain
//  Description : Plain flop chain used as a metastability synchroniser.
//                Ports:
//                  clk     - destination clock
//                  reset_n - synchronous active-low reset, loads RESET_VAL
//                  d       - asynchronous input
//                  q       - output of the last stage
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic d,
    output logic      q
);

    logic [STAGES-1:0] stage_q;
    logic [STAGES-1:0] stage_d;

    // Stage 0 captures the pin; each later stage copies its predecessor.
    always_comb begin
        stage_d = {stage_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_q <= {STAGES{RESET_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/sync_button.sv
`default_nettype none
// ============================================================================
//  Module      : sync_button
//  Description : Conditions one mechanical push-button into the clk domain:
//                synchronise, debounce, and emit one registered single-cycle
//                pulse per accepted press.
//                Ports:
//                  clk     - single clock, all state on posedge
//                  reset_n - synchronous active-low reset
//                  btn     - btn_if slave (btn.in raw pin, btn.out pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_button
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int ACTIVE_LOW      = 1
) (
    input  wire logic clk,
    input  wire logic reset_n,
    btn_if.slave      btn
);

    localparam logic           RELEASED = released_level(ACTIVE_LOW);
    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value at which the next differing sample completes the debounce.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             synced;
    logic [CNT_W-1:0] count_q, count_d;
    logic             state_q, state_d;
    logic             out_q,   out_d;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RELEASED)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (btn.in),
        .q       (synced)
    );

    always_comb begin
        count_d = '0;
        state_d = state_q;
        if (synced != state_q) begin
            // The current differing sample is counted in the same cycle, so
            // the level is accepted on the DEBOUNCE_CYCLES-th consecutive one;
            // the counter therefore never exceeds DEBOUNCE_CYCLES.
            if (count_q >= CNT_LAST) begin
                state_d = synced;
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
        // Pulse is registered on the same edge the state becomes pressed.
        out_d = (state_d != RELEASED) && (state_q == RELEASED);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
            state_q <= RELEASED;
            out_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign btn.out = out_q;

endmodule : sync_button
`default_nettype wire

// File: tb/tb_sync_button.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_button
//  Description : Directed bench for sync_button. Three instances:
//                  u_a - defaults
//                  u_b - DEBOUNCE_CYCLES = 4
//                  u_c - ACTIVE_LOW = 0
//                Inputs change on negedge; outputs sampled 1 unit after posedge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_button;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    always #50 clk = ~clk;

    btn_if if_a ();
    btn_if if_b ();
    btn_if if_c ();

    sync_button u_a (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (if_a)
    );

    sync_button #(.DEBOUNCE_CYCLES(4)) u_b (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (if_b)
    );

    sync_button #(.ACTIVE_LOW(0)) u_c (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (if_c)
    );

    // One clock: drive on negedge, return 1 unit after the following posedge.
    task automatic step(input logic a, input logic b, input logic c, input logic rn);
        @(negedge clk);
        if_a.in = a;
        if_b.in = b;
        if_c.in = c;
        reset_n = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int pulses;
        int doubles;
        logic prev;
        int idle_len;
        int press_len;

        if_a.in = 1'b1;
        if_b.in = 1'b1;
        if_c.in = 1'b0;
        reset_n = 1'b0;

        // Reset held 5 cycles with buttons released: no pulse anywhere.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            chk("rst_a", if_a.out, 1'b0);
            chk("rst_b", if_b.out, 1'b0);
            chk("rst_c", if_c.out, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            chk("post_rst_a", if_a.out, 1'b0);
            chk("post_rst_c", if_c.out, 1'b0);
        end

        // Default press of 10 cycles: pulse only after posedge k+2.
        for (int j = 0; j < 14; j++) begin
            step((j < 10) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b1);
            chk("press10_a", if_a.out, (j == 2));
        end

        // 8 random presses: exactly 8 pulses, never two high cycles in a row.
        pulses  = 0;
        doubles = 0;
        prev    = 1'b0;
        for (int p = 0; p < 8; p++) begin
            idle_len  = int'($urandom_range(5, 2));
            press_len = int'($urandom_range(20, 1));
            for (int i = 0; i < idle_len + press_len; i++) begin
                step((i < idle_len) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b1);
                if (if_a.out === 1'b1) pulses++;
                if (if_a.out === 1'b1 && prev === 1'b1) doubles++;
                prev = if_a.out;
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            if (if_a.out === 1'b1) pulses++;
            if (if_a.out === 1'b1 && prev === 1'b1) doubles++;
            prev = if_a.out;
        end
        chk_int("rand_pulse_count", pulses, 8);
        chk_int("rand_double_high", doubles, 0);

        // DEBOUNCE_CYCLES=4: 3-cycle glitch is ignored.
        for (int j = 0; j < 12; j++) begin
            step(1'b1, (j < 3) ? 1'b0 : 1'b1, 1'b0, 1'b1);
            chk("glitch3_b", if_b.out, 1'b0);
        end
        // 4-cycle press is accepted: pulse after posedge k+5.
        for (int j = 0; j < 12; j++) begin
            step(1'b1, (j < 4) ? 1'b0 : 1'b1, 1'b0, 1'b1);
            chk("press4_b", if_b.out, (j == 5));
        end

        // Reset mid-press on held button: one fresh pulse 2 cycles after reset.
        for (int j = 0; j < 6; j++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            chk("held_a", if_a.out, (j == 2));
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("midrst_a", if_a.out, 1'b0);
        for (int j = 0; j < 8; j++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            chk("after_midrst_a", if_a.out, (j == 2));
        end
        for (int j = 0; j < 4; j++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            chk("release_a", if_a.out, 1'b0);
        end

        // ACTIVE_LOW=0: high-going 3-cycle press gives one pulse, release none.
        for (int j = 0; j < 10; j++) begin
            step(1'b1, 1'b1, (j < 3) ? 1'b1 : 1'b0, 1'b1);
            chk("press_hi_c", if_c.out, (j == 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sync_button
`default_nettype wire
